result_byte_streamer: RTL and testbench
=======================================

# result_byte_streamer

Downstream sink for the processor's 40-bit result bus. It captures every `data` word qualified by `enable` into a FIFO and drains each word as a byte stream, MSB first, over a valid/ready handshake. This stream feeds the board's serial/host output, and it replaces the bench-only text dump of results in hardware.

## Interface
- `DATA_W`, 40: result word width; must be a multiple of 8.
- `DEPTH`, 16: FIFO depth in words; must be a power of 2, at least 2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `data` in DATA_W: result word from the processor.
- `enable` in 1: `data` is valid this cycle; there is no backpressure to the processor.
- `byte_out` out 8: current stream byte.
- `byte_valid` out 1: `byte_out` is valid.
- `byte_ready` in 1: consumer accepts the byte. A transfer occurs on a rising edge where `byte_valid` and `byte_ready` are both 1.
- `full` out 1: FIFO count equals DEPTH.
- `empty` out 1: FIFO count equals 0.
- `count` out $clog2(DEPTH)+1: number of words held in the FIFO, excluding the word in the shift register.
- `overflow` out 1: sticky. Set when `enable` is high while `full` is high. Cleared only by reset.

## Operation
- Write side:
  - `enable` high and `full` low: push `data` at the tail.
  - `enable` high and `full` high: drop the word and set `overflow`.
  - A pop in the same cycle does not free space for that cycle's write. `full` is evaluated on the pre-edge count.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- `count` behaviour per edge:
  - +1 on a push only.
  - −1 on a pop only.
  - Unchanged on a simultaneous push and pop.
- Serializer FSM:
  - IDLE: `byte_valid`=0. If `empty` is low, pop the head into the shift register, clear `byte_idx`, and go to SEND.
  - SEND: `byte_out` = shift register [DATA_W-1 -: 8], `byte_valid`=1. On each transfer, shift left by 8 and increment `byte_idx`.
  - SEND, transfer of byte DATA_W/8−1:
    - With `STREAMER_DELIM_EN`, go to DELIM.
    - Otherwise, if `empty` is low, pop the next word in the same edge and stay in SEND with `byte_idx`=0.
    - Otherwise, go to IDLE.
  - DELIM (macro only): `byte_out`=8'h0A, `byte_valid`=1. On transfer, pop the next word and go to SEND if `empty` is low, else go to IDLE.
- While `byte_valid`=1 and `byte_ready`=0, `byte_out` and the FSM state are held stable.
- `byte_ready` is ignored while `byte_valid`=0.

## Timing
- Reset values:
  - `byte_out`=8'h00, `byte_valid`=0.
  - `count`=0, `empty`=1, `full`=0, `overflow`=0.
  - FSM in IDLE; pointers and `byte_idx` = 0.
- Reset mid-stream discards the FIFO contents and any partially sent word. The first post-reset `enable` is handled as a fresh word.
- Latency: if `enable` is sampled at edge N with the FIFO empty and the FSM in IDLE, the word is popped at edge N+1 and `byte_valid`=1 after edge N+1.
- Throughput with `byte_ready` held at 1:
  - One byte per cycle.
  - Back-to-back words with no bubble: 5 cycles per 40-bit word, or 6 with DELIM.
- All outputs are registered.

## Configuration
- `STREAMER_DELIM_EN` defined: one 8'h0A byte is appended after every word. The line-oriented host log gets one line per result word.
- `STREAMER_DELIM_EN` undefined: the DELIM state is not compiled, and the stream is raw concatenated words.

## Test plan
- Reset: hold `rst`=0 with `enable`=1 and arbitrary `data`. Required response: all outputs stay at their reset values. After release, `count`=0 until the first `enable`.
- Single word, `byte_ready`=1: `enable` pulse with `data`=40'h0123456789. Required response: `byte_out` is 01, 23, 45, 67, 89 on 5 consecutive cycles starting 1 cycle after the push, then `byte_valid`=0. With the macro, 0A follows 89.
- Backpressure: toggle `byte_ready` every cycle while streaming 40'hFFEEDDCCBB. Required response: each byte is held until accepted, byte order is unchanged, and no byte is duplicated or skipped.
- Overflow, DEPTH=16, `byte_ready`=0:
  - Push 18 words. Required response: the first word moves to the shift register, so `count` reaches 16 and `full`=1. The 18th push is dropped and `overflow`=1.
  - Then drain. Required response: exactly 17 words are output, in order.
- Back-to-back: push words 40'h1 through 40'h4 on consecutive cycles with `byte_ready`=1. Required response: 20 consecutive valid bytes with no gap, or 24 with the macro. Pointers wrap correctly after DEPTH+4 total words.
- Reset mid-word: assert `rst` after 2 bytes of 40'hA1B2C3D4E5 have been sent, with 3 words queued. Required response: outputs return to reset values immediately. After release, no stale bytes appear.

Source files
------------

// File: rtl/result_byte_streamer.sv
// Result-word FIFO feeding an MSB-first byte stream over valid/ready.
// Optional macro STREAMER_DELIM_EN appends an 8'h0A byte after every word.
`timescale 1ns/1ps
module result_byte_streamer #(
  parameter int unsigned DATA_W = 40,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data,
  input  logic                      enable,
  output logic [7:0]                byte_out,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

`ifdef STREAMER_DELIM_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DELIM} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_full, r_empty, r_overflow;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic [DATA_W-1:0]   w_shift_sh;
  logic [DATA_W-1:0]   w_head;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [7:0]          r_byte_out, w_out_nxt;
  logic                r_byte_valid, w_valid_nxt;
  logic                w_push, w_pop, w_xfer;

  assign w_push     = enable & ~r_full;
  assign w_xfer     = r_byte_valid & byte_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_shift_sh = r_shift << 8;
  assign w_cnt_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Storage array: no reset needed, contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data;
  end

  // Pointers, occupancy and status flags; full/empty registered from next count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
      if (enable && r_full) r_overflow <= 1'b1;
    end
  end

  // Serializer state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_idx        <= '0;
      r_byte_out   <= 8'h00;
      r_byte_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_idx        <= w_idx_nxt;
      r_byte_out   <= w_out_nxt;
      r_byte_valid <= w_valid_nxt;
    end
  end

  // Next-state logic; a word load always presents its top byte on the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_out_nxt   = r_byte_out;
    w_valid_nxt = r_byte_valid;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_idx_nxt   = '0;
          w_out_nxt   = w_head[DATA_W-1 -: 8];
          w_valid_nxt = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
`ifdef STREAMER_DELIM_EN
            w_state_nxt = S_DELIM;
            w_out_nxt   = 8'h0A;
            w_valid_nxt = 1'b1;
`else
            if (!r_empty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_idx_nxt   = '0;
              w_out_nxt   = w_head[DATA_W-1 -: 8];
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
              w_out_nxt   = 8'h00;
              w_valid_nxt = 1'b0;
            end
`endif
          end else begin
            w_shift_nxt = w_shift_sh;
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_out_nxt   = w_shift_sh[DATA_W-1 -: 8];
            w_valid_nxt = 1'b1;
          end
        end
      end
`ifdef STREAMER_DELIM_EN
      S_DELIM: begin
        if (w_xfer) begin
          if (!r_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_idx_nxt   = '0;
            w_out_nxt   = w_head[DATA_W-1 -: 8];
            w_valid_nxt = 1'b1;
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = 8'h00;
            w_valid_nxt = 1'b0;
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_result_byte_streamer.sv
// Scoreboard bench for result_byte_streamer: stimulus queues expected bytes,
// a negedge monitor pops and compares on every accepted byte.
`timescale 1ns/1ps
module tb_result_byte_streamer;

  localparam int unsigned DATA_W = 40;
  localparam int unsigned DEPTH  = 16;
`ifdef STREAMER_DELIM_EN
  localparam int WORD_BYTES = 6;
`else
  localparam int WORD_BYTES = 5;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data;
  logic              enable;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              full;
  logic              empty;
  logic [4:0]        count;
  logic              overflow;

  result_byte_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .enable     (enable),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  int         cyc   = 0;
  int         vcnt  = 0;
  int         vfirst = -1;
  int         vlast  = -1;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_o = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_word(input logic [DATA_W-1:0] w);
    for (int i = 4; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
`ifdef STREAMER_DELIM_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    enable = 1'b1;
    data   = w;
    exp_word(w);
    step();
    enable = 1'b0;
  endtask

  task automatic meas_start();
    vcnt   = 0;
    vfirst = -1;
    vlast  = -1;
  endtask

  task automatic drain(input bit toggle, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || byte_valid) && n < 1000) begin
      if (toggle) byte_ready = ~byte_ready;
      step();
      n++;
    end
    chk({name, "_left_in_sb"}, 64'(exp_q.size()), 64'(0));
    chk({name, "_idle_valid"}, 64'(byte_valid), 64'(0));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_valid"},    64'(byte_valid), 64'(0));
    chk({name, "_byte"},     64'(byte_out),   64'(0));
    chk({name, "_count"},    64'(count),      64'(0));
    chk({name, "_empty"},    64'(empty),      64'(1));
    chk({name, "_full"},     64'(full),       64'(0));
    chk({name, "_overflow"}, 64'(overflow),   64'(0));
  endtask

  // Monitor: a byte is accepted at the next rising edge when valid&ready here.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
      prev_o = 8'h00;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", 64'(byte_valid), 64'(1));
        chk("hold_byte",  64'(byte_out),   64'(prev_o));
      end
      if (byte_valid) begin
        vcnt++;
        if (vfirst < 0) vfirst = cyc;
        vlast = cyc;
      end
      if (byte_valid && byte_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stray_byte: got %0h expected no byte (t=%0t)", byte_out, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (byte_out !== e) begin
            bad++;
            $display("FAIL stream_byte: got %0h expected %0h (t=%0t)", byte_out, e, $time);
          end
        end
      end
      prev_v = byte_valid;
      prev_r = byte_ready;
      prev_o = byte_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    enable     = 1'b1;
    data       = 40'hDEADBEEF01;
    byte_ready = 1'b1;

    // Reset held with enable active
    for (int i = 0; i < 4; i++) begin
      step();
      data = {$urandom, 8'h5A};
      chk_reset_vals("in_reset");
    end
    enable = 1'b0;
    rst    = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_count", 64'(count), 64'(0));
      chk("post_rst_empty", 64'(empty), 64'(1));
    end

    // Single word, latency and contiguous bytes
    meas_start();
    push_word(40'h0123456789);
    chk("lat_pre_valid", 64'(byte_valid), 64'(0));
    chk("count_one",     64'(count),      64'(1));
    step();
    chk("lat_valid",     64'(byte_valid), 64'(1));
    chk("lat_first",     64'(byte_out),   64'(8'h01));
    chk("count_popped",  64'(count),      64'(0));
    drain(1'b0, "single");
    chk("single_bytes",  64'(vcnt),              64'(WORD_BYTES));
    chk("single_contig", 64'(vlast - vfirst + 1), 64'(vcnt));

    // Backpressure: ready toggles every cycle
    byte_ready = 1'b0;
    push_word(40'hFFEEDDCCBB);
    drain(1'b1, "bp");

    // Overflow with the consumer stalled
    byte_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_word(40'hC000000000 | 40'(i));
      if (i == 1) chk("ovf_count_after2", 64'(count), 64'(1));
    end
    chk("ovf_count16", 64'(count),    64'(16));
    chk("ovf_full",    64'(full),     64'(1));
    chk("ovf_empty",   64'(empty),    64'(0));
    chk("ovf_pre",     64'(overflow), 64'(0));
    enable = 1'b1;
    data   = 40'hEEEEEEEEEE;
    step();
    enable = 1'b0;
    chk("ovf_set",     64'(overflow), 64'(1));
    chk("ovf_count_hold", 64'(count), 64'(16));
    meas_start();
    byte_ready = 1'b1;
    drain(1'b0, "ovf");
    chk("ovf_drain_bytes", 64'(vcnt),              64'(17 * WORD_BYTES));
    chk("ovf_contig",      64'(vlast - vfirst + 1), 64'(vcnt));
    chk("ovf_sticky",      64'(overflow), 64'(1));
    chk("ovf_drain_empty", 64'(empty),    64'(1));

    // Back-to-back words, pointers already wrapped
    meas_start();
    for (int w = 1; w <= 4; w++) push_word(40'(w));
    drain(1'b0, "b2b");
    chk("b2b_bytes",  64'(vcnt),              64'(4 * WORD_BYTES));
    chk("b2b_contig", 64'(vlast - vfirst + 1), 64'(vcnt));
    chk("b2b_count",  64'(count), 64'(0));

    // Reset in the middle of a word with three words queued
    byte_ready = 1'b0;
    push_word(40'hA1B2C3D4E5);
    push_word(40'h1111111111);
    push_word(40'h2222222222);
    push_word(40'h3333333333);
    chk("mid_count3", 64'(count), 64'(3));
    byte_ready = 1'b1;
    step();
    step();
    exp_q.delete();
    rst = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    step();
    step();
    rst = 1'b1;
    repeat (6) begin
      step();
      chk("no_stale_valid", 64'(byte_valid), 64'(0));
    end
    push_word(40'h0A0B0C0D0E);
    drain(1'b0, "fresh");
    chk("fresh_count", 64'(count), 64'(0));

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
